// File: rtl/eth_rx_drv_pkg.sv
// Shared definitions for the Ethernet receive driver: FSM state encoding
// and the MII preamble/SFD nibble values.
package eth_rx_drv_pkg;

  typedef enum logic [2:0] {
    RX_STATE_IDLE     = 3'd0,
    RX_STATE_PREAMBLE = 3'd1,
    RX_STATE_CAPTURE  = 3'd2,
    RX_STATE_DRAIN    = 3'd3,
    RX_STATE_DISCARD  = 3'd4,
    RX_STATE_HOLD     = 3'd5
  } rx_state_t;

  localparam logic [3:0] ETH_PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] ETH_SFD_NIBBLE      = 4'hD;

endpackage

// File: rtl/eth_rx_drv_if.sv
// Frame handoff between the receive driver (slave) and the frame reader
// (master): read request/ready plus the held frame and its attributes.
interface eth_rx_drv_if #(
  parameter int ETH_MAX_FRAME_SIZE = 256
) ();
  localparam int LEN_W = $clog2(ETH_MAX_FRAME_SIZE / 8) + 1;

  logic                          rx_drv_rd_valid;
  logic                          rx_drv_rd_ready;
  logic [ETH_MAX_FRAME_SIZE-1:0] rx_drv_rd_data;
  logic [LEN_W-1:0]              rx_frame_len;
  logic                          rx_frame_trunc;

  modport master (
    output rx_drv_rd_valid,
    input  rx_drv_rd_ready,
    input  rx_drv_rd_data,
    input  rx_frame_len,
    input  rx_frame_trunc
  );

  modport slave (
    input  rx_drv_rd_valid,
    output rx_drv_rd_ready,
    output rx_drv_rd_data,
    output rx_frame_len,
    output rx_frame_trunc
  );
endinterface

// File: rtl/eth_sat_counter.sv
// Event counter that sticks at all-ones; cleared only by reset.
module eth_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment on each event pulse until saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {WIDTH{1'b0}};
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/eth_rx_drv.sv
// MII receive driver: finds preamble/SFD, packs the payload MSB-first into a
// frame buffer and holds it for the reader behind a valid/ready handshake.
module eth_rx_drv
  import eth_rx_drv_pkg::*;
#(
  parameter int ETH_MAX_FRAME_SIZE = 256,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mii_rx_en,
  input  logic [3:0]           mii_rxd,
  input  logic                 mii_rx_dv,
  input  logic                 mii_rx_er,
  eth_rx_drv_if.slave          rd,
  output logic [CNT_WIDTH-1:0] rx_err_cnt,
  output logic [CNT_WIDTH-1:0] rx_drop_cnt,
  output logic [2:0]           rx_fsm_state
);

  localparam int MAX   = ETH_MAX_FRAME_SIZE;
  localparam int NIB_W = $clog2(MAX / 4) + 1;
  localparam int LEN_W = $clog2(MAX / 8) + 1;
  localparam int IDX_W = $clog2(MAX);
  localparam logic [NIB_W-1:0] NIB_LIMIT = NIB_W'(MAX / 4);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX / 8);

  rx_state_t        state_r;
  logic [MAX-1:0]   frame_r;
  logic [NIB_W-1:0] nib_cnt_r;
  logic [LEN_W-1:0] len_r;
  logic             trunc_r;
  logic             ready_r;
  logic             last_dv_r;
  logic             err_inc_r;
  logic             drop_inc_r;

  logic             dv_now_s;
  logic [IDX_W-1:0] nib_lsb_s;

  // Nibble n lands in byte n/2 counted from the top; the even nibble is the low half.
  always_comb begin
    dv_now_s  = mii_rx_en ? mii_rx_dv : last_dv_r;
    nib_lsb_s = IDX_W'(MAX - 8)
              - IDX_W'({nib_cnt_r[NIB_W-1:1], 3'b000})
              + IDX_W'({nib_cnt_r[0], 2'b00});
  end

  // Receive FSM with frame buffer, length/trunc capture and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RX_STATE_IDLE;
      frame_r    <= {MAX{1'b0}};
      nib_cnt_r  <= {NIB_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      trunc_r    <= 1'b0;
      ready_r    <= 1'b0;
      last_dv_r  <= 1'b0;
      err_inc_r  <= 1'b0;
      drop_inc_r <= 1'b0;
    end else begin
      err_inc_r  <= 1'b0;
      drop_inc_r <= 1'b0;
      if (mii_rx_en) begin
        last_dv_r <= mii_rx_dv;
      end
      case (state_r)
        RX_STATE_IDLE: begin
          if (mii_rx_en && mii_rx_dv) begin
            state_r <= (mii_rxd == ETH_PREAMBLE_NIBBLE) ? RX_STATE_PREAMBLE : RX_STATE_DISCARD;
          end
        end
        RX_STATE_PREAMBLE: begin
          if (mii_rx_en) begin
            if (!mii_rx_dv) begin
              state_r <= RX_STATE_IDLE;
            end else if (mii_rx_er) begin
              err_inc_r <= 1'b1;
              state_r   <= RX_STATE_DISCARD;
            end else if (mii_rxd == ETH_PREAMBLE_NIBBLE) begin
              state_r <= RX_STATE_PREAMBLE;
            end else if (mii_rxd == ETH_SFD_NIBBLE) begin
              frame_r   <= {MAX{1'b0}};
              nib_cnt_r <= {NIB_W{1'b0}};
              trunc_r   <= 1'b0;
              state_r   <= RX_STATE_CAPTURE;
            end else begin
              state_r <= RX_STATE_DISCARD;
            end
          end
        end
        RX_STATE_CAPTURE: begin
          if (mii_rx_en) begin
            if (mii_rx_dv && mii_rx_er) begin
              err_inc_r <= 1'b1;
              state_r   <= RX_STATE_DISCARD;
            end else if (mii_rx_dv && (nib_cnt_r == NIB_LIMIT)) begin
              trunc_r <= 1'b1;
              state_r <= RX_STATE_DRAIN;
            end else if (mii_rx_dv) begin
              frame_r[nib_lsb_s +: 4] <= mii_rxd;
              nib_cnt_r               <= nib_cnt_r + NIB_W'(1);
            end else if (!nib_cnt_r[0] && (nib_cnt_r != {NIB_W{1'b0}})) begin
              len_r   <= LEN_W'(nib_cnt_r >> 1);
              ready_r <= 1'b1;
              state_r <= RX_STATE_HOLD;
            end else begin
              err_inc_r <= 1'b1;
              state_r   <= RX_STATE_IDLE;
            end
          end
        end
        RX_STATE_DRAIN: begin
          if (mii_rx_en && !mii_rx_dv) begin
            len_r   <= LEN_FULL;
            ready_r <= 1'b1;
            state_r <= RX_STATE_HOLD;
          end
        end
        RX_STATE_DISCARD: begin
          if (mii_rx_en && !mii_rx_dv) begin
            state_r <= RX_STATE_IDLE;
          end
        end
        RX_STATE_HOLD: begin
          // A frame starting while one is held is lost; a concurrent transfer still completes.
          if (mii_rx_en && mii_rx_dv && !last_dv_r) begin
            drop_inc_r <= 1'b1;
          end
          if (rd.rx_drv_rd_valid && ready_r) begin
            ready_r <= 1'b0;
            state_r <= dv_now_s ? RX_STATE_DISCARD : RX_STATE_IDLE;
          end
        end
        default: begin
          ready_r <= 1'b0;
          state_r <= RX_STATE_IDLE;
        end
      endcase
    end
  end

  eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc_r),
    .count (rx_err_cnt)
  );

  eth_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc_r),
    .count (rx_drop_cnt)
  );

  assign rd.rx_drv_rd_ready = ready_r;
  assign rd.rx_drv_rd_data  = frame_r;
  assign rd.rx_frame_len    = len_r;
  assign rd.rx_frame_trunc  = trunc_r;
  assign rx_fsm_state       = state_r;

endmodule

// File: doc/eth_rx_drv.md
# eth_rx_drv

Receive driver directly upstream of the Ethernet frame reader. It detects preamble and SFD on an MII-style 4-bit receive interface and assembles the frame payload, MSB-first, into a single ETH_MAX_FRAME_SIZE-bit frame buffer. It then presents the buffer through a request/ready handshake: the reader raises `rx_drv_rd_valid`, and the driver answers with `rx_drv_rd_ready` while a complete frame is held. Status flags and saturating counters report truncated, errored and dropped frames.

## Interface
- ETH_MAX_FRAME_SIZE, 256, frame buffer width in bits; must be a multiple of 8.
- CNT_WIDTH, 8, width of the error and drop counters.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- mii_rx_en  in  1  nibble strobe. MII inputs are sampled only on cycles where this is 1.
- mii_rxd  in  4  receive nibble.
- mii_rx_dv  in  1  receive data valid.
- mii_rx_er  in  1  receive error.
- rx_drv_rd_valid  in  1  read request from the reader.
- rx_drv_rd_ready  out  1  a complete frame is held, and `rx_drv_rd_data` is valid and stable.
- rx_drv_rd_data  out  ETH_MAX_FRAME_SIZE  frame buffer. The first received byte occupies bits [MAX-1:MAX-8].
- rx_frame_len  out  $clog2(ETH_MAX_FRAME_SIZE/8)+1  byte count of the held frame.
- rx_frame_trunc  out  1  the held frame exceeded the buffer and was truncated.
- rx_err_cnt  out  CNT_WIDTH  count of errored frames; saturates at all-ones.
- rx_drop_cnt  out  CNT_WIDTH  count of frames dropped because the buffer was full; saturates.
- rx_fsm_state  out  3  current state, for debug and register readback.

## Operation
A "strobe" below means a cycle with mii_rx_en=1. All state transitions happen on strobes, except the exit from HOLD.

**States**
- IDLE
  - Strobe with dv=1 and rxd=0x5: go to PREAMBLE.
  - Strobe with dv=1 and any other nibble: go to DISCARD.
- PREAMBLE
  - rxd=0x5: stay in PREAMBLE.
  - rxd=0xD (SFD high nibble): clear the buffer to zero, clear the nibble counter, clear the trunc flag, then go to CAPTURE.
  - Any other nibble: go to DISCARD.
  - dv=0: go to IDLE, with no counter change.
- CAPTURE
  - Each strobe with dv=1 writes nibble index n = nibble counter.
    - Byte b = n/2.
    - Even n writes bits [MAX-1-8b-4 : MAX-8-8b] (low nibble first).
    - Odd n writes bits [MAX-1-8b : MAX-4-8b].
    - The counter then increments.
  - When n reaches MAX/4 with dv still 1: set trunc and go to DRAIN.
  - dv=0 with an even, nonzero count: rx_frame_len = count/2, go to HOLD.
  - dv=0 with an odd count or a zero count: err_cnt++, go to IDLE.
- DRAIN
  - Nibbles are ignored.
  - dv=0: rx_frame_len = MAX/8, go to HOLD.
- DISCARD
  - Wait for a strobe with dv=0, then go to IDLE.
- HOLD
  - rx_drv_rd_ready=1.
  - rd_data, rx_frame_len and rx_frame_trunc are frozen.
  - A dv 0→1 transition seen on a strobe: drop_cnt++, and that frame is ignored.
  - rd_valid && rd_ready: leave HOLD the next cycle. The next state is DISCARD if the last sampled dv=1, otherwise IDLE.

**Error handling**
- mii_rx_er=1 with dv=1 on a strobe in PREAMBLE or CAPTURE: err_cnt++, go to DISCARD.
- rx_er is ignored in DRAIN, HOLD and DISCARD.

**Counters**
- Both counters saturate at 2^CNT_WIDTH-1.
- They clear only on reset.

## Timing
**Reset values**
- State = IDLE.
- rx_drv_rd_ready=0.
- rx_drv_rd_data=0.
- rx_frame_len=0.
- rx_frame_trunc=0.
- Both counters 0.

**Latency and handshake**
- rd_ready rises in the cycle after the strobe that sampled dv=0 at frame end.
- rd_ready stays high, independent of rd_valid, until the transfer cycle.
- Transfer occurs in the cycle where rd_valid && rd_ready; the reader samples rd_data in that cycle.
- rd_ready is 0 in the next cycle.
- rd_data holds its value after the transfer until the next SFD clears it.
- rd_valid held high while no frame is pending has no effect.

**Simultaneous events and mid-operation reset**
- A transfer in the same cycle as a dv-rising strobe counts as a drop, and the next state is DISCARD.
- Reset mid-frame returns to IDLE. If dv is still high after reset, the first strobe sees a non-preamble nibble (or mid-frame data) and goes to DISCARD unless the nibble is 0x5.

## Structure
- Add to the shared `eth_defs.vh`:
  - `RX_STATE_IDLE=0`, `RX_STATE_PREAMBLE=1`, `RX_STATE_CAPTURE=2`, `RX_STATE_DRAIN=3`, `RX_STATE_DISCARD=4`, `RX_STATE_HOLD=5`
  - `ETH_PREAMBLE_NIBBLE=4'h5`, `ETH_SFD_NIBBLE=4'hD`
- Single sub-module `eth_sat_counter` (parameter WIDTH; ports clk, rst, inc, count), instantiated twice for the error and drop counters.
- The remaining logic is one FSM plus the nibble-placement datapath.

## Test plan
- Good frame: 15×0x5, 0xD, then bytes 0x01..0x04 (8 nibbles), then dv=0.
  - rd_ready=1; rd_data[255:224]=0x01020304, all lower bits 0; len=4; trunc=0.
- Oversize frame: 40 bytes after the SFD.
  - len=32, trunc=1, rd_data holds bytes 1..32.
- rx_er pulsed mid-CAPTURE:
  - err_cnt=1, no rd_ready.
  - The following good frame is captured normally.
- A second frame arrives while in HOLD with rd_valid=0:
  - drop_cnt=1, rd_data is unchanged.
  - Assert rd_valid for one cycle → rd_ready falls the next cycle.
- Frame ends after 3 nibbles → err_cnt++, state IDLE.
- Reset asserted during CAPTURE: all outputs return to their reset values the next cycle.
- Counter saturation: 300 errored frames → err_cnt=255.
